// File: rtl/serial_loader.sv
// serial_loader
//   Serial-to-parallel front end. Detects a start bit (0), shifts in WIDTH
//   data bits LSB first, checks the stop bit (1) and presents each correctly
//   framed word on data_out with a single-cycle load strobe for the
//   downstream holding register. Malformed frames give a frame_err pulse.
//
//   Optional feature: define SERIAL_LOADER_PARITY_EN to expect one parity
//   bit between the last data bit and the stop bit.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   serial_in    : serial line bit, sampled when serial_valid = 1
//   serial_valid : qualifies serial_in; 0 = stall cycle
//   data_out     : last correctly framed word (held between loads)
//   load         : one-cycle strobe marking a new data_out
//   busy         : frame in progress (FSM not idle)
//   frame_err    : one-cycle pulse when a frame is rejected
module serial_loader #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

`ifdef SERIAL_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd3
    } state_t;
`endif

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   shift_q,     shift_d;
    logic [WIDTH-1:0]   data_out_q,  data_out_d;
    logic               load_q,      load_d;
    logic               busy_q,      busy_d;
    logic               frame_err_q, frame_err_d;
    logic               par_err_q,   par_err_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        par_err_d   = par_err_q;
        load_d      = 1'b0;
        frame_err_d = 1'b0;

        if (serial_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        par_err_d = 1'b0;
                    end
                end
                DATA: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) shift_d[i] = serial_in;
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_LOADER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SERIAL_LOADER_PARITY_EN
                PAR: begin
                    // Expected parity bit is the XNOR reduction of the word.
                    par_err_d = (serial_in != ~^shift_q);
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    if (serial_in && !par_err_q) begin
                        data_out_d = shift_q;
                        load_d     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
        end
    end

    assign data_out  = data_out_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (WIDTH = 4).
module tb_serial_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_in = 1'b1;
    logic       serial_valid = 1'b0;
    logic [3:0] data_out;
    logic       load;
    logic       busy;
    logic       frame_err;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    serial_loader #(.WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (data_out),
        .load         (load),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        serial_valid = 1'b1;
        serial_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic stall_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            serial_valid = 1'b0;
            serial_in    = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, data bits LSB first, and (parity builds) the parity bit.
    // After each bit before the stop bit, no strobe may appear and busy is high.
    task automatic send_body(input string name, input logic [3:0] d, input logic par);
        logic [3:0] dv;
        dv = d;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({load, frame_err, busy} !== 3'b001)
                $display("FAIL %s_body: load/ferr/busy=%b required 001", name, {load, frame_err, busy});
            else n_pass++;
            send_bit(dv[i]);
        end
`ifdef SERIAL_LOADER_PARITY_EN
        n_total++;
        if ({load, frame_err, busy} !== 3'b001)
            $display("FAIL %s_prepar: load/ferr/busy=%b required 001", name, {load, frame_err, busy});
        else n_pass++;
        send_bit(par);
`else
        if (par) begin end
`endif
        n_total++;
        if ({load, frame_err, busy} !== 3'b001)
            $display("FAIL %s_prestop: load/ferr/busy=%b required 001", name, {load, frame_err, busy});
        else n_pass++;
    endtask

    task automatic check_loaded(input string name, input logic [3:0] exp);
        n_total++;
        if ({load, frame_err, busy} !== 3'b100)
            $display("FAIL %s_strobe: load/ferr/busy=%b required 100", name, {load, frame_err, busy});
        else n_pass++;
        n_total++;
        if (data_out !== exp)
            $display("FAIL %s_data: data_out=%b required %b", name, data_out, exp);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        serial_valid = 1'b1;
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({data_out, load, busy, frame_err} !== 7'b0)
            $display("FAIL reset: data_out/load/busy/ferr=%b required 0000000", {data_out, load, busy, frame_err});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_idle_line;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1);
            n_total++;
            if ({data_out, load, busy, frame_err} !== 7'b0)
                $display("FAIL idle_line: outputs=%b required 0000000", {data_out, load, busy, frame_err});
            else n_pass++;
        end
    endtask

    task automatic test_frame;
        send_body("frame", 4'b1101, 1'b0);
        send_bit(1'b1);
        check_loaded("frame", 4'b1101);
        send_bit(1'b1);
        n_total++;
        if ({load, frame_err, busy} !== 3'b000 || data_out !== 4'b1101)
            $display("FAIL frame_after: load/ferr/busy=%b data_out=%b required 000 1101",
                     {load, frame_err, busy}, data_out);
        else n_pass++;
    endtask

    task automatic test_stop_error;
        send_body("stoperr", 4'b1111, 1'b1);
        send_bit(1'b0);
        n_total++;
        if ({load, frame_err, busy} !== 3'b010)
            $display("FAIL stoperr_strobe: load/ferr/busy=%b required 010", {load, frame_err, busy});
        else n_pass++;
        n_total++;
        if (data_out !== 4'b1101)
            $display("FAIL stoperr_hold: data_out=%b required 1101", data_out);
        else n_pass++;
        send_bit(1'b1);
        n_total++;
        if ({load, frame_err} !== 2'b00)
            $display("FAIL stoperr_pulse: load/ferr=%b required 00", {load, frame_err});
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        n_total++;
        if ({load, frame_err, busy} !== 3'b000 || data_out !== 4'b0000)
            $display("FAIL abort_reset: load/ferr/busy=%b data_out=%b required 000 0000",
                     {load, frame_err, busy}, data_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            n_total++;
            if ({load, frame_err, busy} !== 3'b000)
                $display("FAIL abort_quiet: load/ferr/busy=%b required 000", {load, frame_err, busy});
            else n_pass++;
        end
        send_body("abort", 4'b1100, 1'b1);
        send_bit(1'b1);
        check_loaded("abort", 4'b1100);
    endtask

    task automatic test_stall;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        stall_cycles(1);
        n_total++;
        if ({load, frame_err, busy} !== 3'b001 || data_out !== 4'b1100)
            $display("FAIL stall_hold1: load/ferr/busy=%b data_out=%b required 001 1100",
                     {load, frame_err, busy}, data_out);
        else n_pass++;
        stall_cycles(2);
        n_total++;
        if ({load, frame_err, busy} !== 3'b001 || data_out !== 4'b1100)
            $display("FAIL stall_hold3: load/ferr/busy=%b data_out=%b required 001 1100",
                     {load, frame_err, busy}, data_out);
        else n_pass++;
        send_bit(1'b1);
        send_bit(1'b1);
`ifdef SERIAL_LOADER_PARITY_EN
        send_bit(1'b0);
`endif
        n_total++;
        if (load !== 1'b0)
            $display("FAIL stall_early: load=%b required 0", load);
        else n_pass++;
        send_bit(1'b1);
        check_loaded("stall", 4'b1101);
        stall_cycles(1);
        n_total++;
        if ({load, frame_err} !== 2'b00)
            $display("FAIL stall_pulse: load/ferr=%b required 00", {load, frame_err});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        send_body("b2b_a", 4'b0001, 1'b0);
        send_bit(1'b1);
        check_loaded("b2b_a", 4'b0001);
        // start bit of the next frame while load is high
        send_body("b2b_b", 4'b1010, 1'b1);
        send_bit(1'b1);
        check_loaded("b2b_b", 4'b1010);
    endtask

`ifdef SERIAL_LOADER_PARITY_EN
    task automatic test_parity;
        send_body("par_bad", 4'b0111, 1'b1);
        send_bit(1'b1);
        n_total++;
        if ({load, frame_err, busy} !== 3'b010 || data_out !== 4'b1010)
            $display("FAIL par_bad: load/ferr/busy=%b data_out=%b required 010 1010",
                     {load, frame_err, busy}, data_out);
        else n_pass++;
        send_body("par_good", 4'b0111, 1'b0);
        send_bit(1'b1);
        check_loaded("par_good", 4'b0111);
    endtask
`endif

    initial begin
        test_reset();
        test_idle_line();
        test_frame();
        test_stop_error();
        test_reset_abort();
        test_stall();
        test_back_to_back();
`ifdef SERIAL_LOADER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
